heat_column_store: RTL and testbench
====================================

Name: heat_column_store

Overview:
- Per-column pixel store that sits directly downstream of the HPS-to-FPGA read loop.
- One instance per screen column. The upstream loop drives this column's bit of the one-hot column select, a row number and an 8-bit signed heat value; this block writes the value into its M10K and returns the acknowledge bit.
- A second, read-only port serves the VGA scan-out.
- Also supports saturating accumulate writes and a full-column clear sweep.

Parameters:
- ROWS, 480, number of valid rows stored (depth of the M10K).
- ROW_W, 10, width of the row address.
- VAL_W, 8, width of the signed heat value.

Ports:
- clock  in  1  single system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- col_sel  in  1  this column's bit of the upstream column select; held high until col_ack is seen.
- row_sel  in  ROW_W  target row; sampled when a request is accepted.
- wr_data  in  VAL_W  signed heat value; sampled with row_sel.
- accum_en  in  1  1 = add wr_data to stored value with saturation; 0 = overwrite. Sampled with row_sel.
- col_ack  out  1  return/acknowledge bit to upstream.
- clear_req  in  1  single-cycle pulse: fill the whole column with clear_val.
- clear_val  in  VAL_W  fill value; sampled on the cycle the clear starts.
- clear_busy  out  1  high while the clear sweep runs.
- range_err  out  1  sticky flag: a request arrived with row_sel >= ROWS.
- vga_row  in  ROW_W  VGA read address.
- vga_data  out  VAL_W  stored value at vga_row, 2-cycle latency.

Behaviour:
- Reset (asynchronous): state=IDLE; col_ack=0, clear_busy=0, range_err=0, clear pending=0. vga_data pipeline registers are reset to 0. M10K contents are not reset (undefined after power-up); software issues a clear.
- Memory: simple dual-port M10K.
  - Port A is owned by the FSM (read and write).
  - Port B is VGA read-only: address registered, output registered, so vga_data reflects vga_row from 2 cycles earlier.
  - Same-address read during write on port B returns the old data.
- FSM states: IDLE, CLEAR, RD_ADDR, RD_WAIT, WRITE, ACK.
- IDLE, checks in priority order:
  - clear_req or clear pending: go to CLEAR, address=0, latch clear_val, clear_busy=1 from the next cycle.
  - Else if col_sel=1: latch row_sel, wr_data, accum_en.
    - row_sel >= ROWS: set range_err, go to ACK with no memory write.
    - accum_en=0: go to WRITE.
    - accum_en=1: go to RD_ADDR.
- RD_ADDR then RD_WAIT: port A read of the latched row. Read data is valid at the end of RD_WAIT.
- WRITE:
  - Write the latched value, or for accumulate the saturated sum, then go to ACK.
  - Sum is computed at VAL_W+1 bits signed and clamped to [-128, 127].
- ACK:
  - col_ack=1 while col_sel=1.
  - When col_sel=0, go to IDLE and drop col_ack on the next edge.
  - This is a four-phase handshake: a new request cannot start until col_ack has returned to 0.
- Latency, with col_sel first high in cycle 0 and the FSM in IDLE:
  - Overwrite: col_ack high in cycle 2.
  - Accumulate: col_ack high in cycle 4.
  - Out-of-range: col_ack high in cycle 1.
- CLEAR:
  - Writes the latched clear_val to rows 0..ROWS-1, one per cycle (480 cycles).
  - On the last row: clear_busy=0, range_err cleared, return to IDLE.
  - col_sel held during the clear is served afterwards; upstream simply keeps waiting.
- clear_req arriving in any non-IDLE state sets the pending flag; the clear runs on the next entry to IDLE.
- clear_req during CLEAR is ignored; no pending flag is set.
- clear_req and col_sel together in IDLE: the clear wins.
- col_sel dropping before col_ack (protocol violation): an accepted request still completes its write. ACK then sees col_sel=0 and returns to IDLE, producing a single-cycle col_ack pulse.
- Reset asserted mid-write or mid-clear: the operation is abandoned and memory is partially updated. Upstream must restart its handshake.

Decomposition:
- heat_pkg holds:
  - ROWS, ROW_W, VAL_W constants.
  - FSM state encoding.
  - sat_add function (signed saturating add, VAL_W in, VAL_W out).
- One sub-module, heat_col_m10k: inferred simple dual-port RAM with registered read on both ports. Keeping it separate keeps M10K inference clean.

Test Plan:
- Overwrite: col_sel=1, row_sel=5, wr_data=0x23, accum_en=0 -> col_ack high in cycle 2. Drop col_sel -> col_ack low in the next cycle. vga_row=5 -> vga_data=0x23 two cycles later.
- Accumulate saturation: row 7 holds 100; accumulate +50 -> stored 127. Row 8 holds -100; accumulate -60 -> stored -128. col_ack in cycle 4 for each.
- Clear: clear_val=0xF6, pulse clear_req -> clear_busy high for 480 cycles. VGA reads of rows 0, 239, 479 return 0xF6. range_err is 0 afterwards.
- Clear vs request: clear_req and col_sel (row 3, value 9) asserted in the same cycle -> clear runs first, then row 3 is written with 9. col_ack arrives 2 cycles after clear_busy falls.
- Out-of-range: row_sel=480 -> col_ack in cycle 1, range_err=1, no memory change. A subsequent clear resets range_err.
- Async reset: assert reset during accumulate state RD_WAIT -> col_ack, clear_busy, range_err all 0 immediately with no clock edge; the FSM accepts a new request after reset is released.

Source files
------------

// File: rtl/heat_pkg.sv
// Shared constants, FSM encoding and the saturating add for the heat column store.
package heat_pkg;

  localparam int ROWS  = 480;
  localparam int ROW_W = 10;
  localparam int VAL_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RD_ADDR,
    RD_WAIT,
    WRITE,
    ACK
  } state_t;

  // Signed add at VAL_W+1 bits, clamped to the signed VAL_W range.
  function automatic logic [VAL_W-1:0] sat_add(input logic signed [VAL_W-1:0] a,
                                               input logic signed [VAL_W-1:0] b);
    logic [VAL_W:0] s;
    s = {a[VAL_W-1], a} + {b[VAL_W-1], b};
    case (s[VAL_W:VAL_W-1])
      2'b01:   sat_add = {1'b0, {(VAL_W-1){1'b1}}};
      2'b10:   sat_add = {1'b1, {(VAL_W-1){1'b0}}};
      default: sat_add = s[VAL_W-1:0];
    endcase
  endfunction

endpackage

// File: rtl/heat_col_m10k.sv
// Simple dual-port RAM, registered reads on both ports; port B is read-only.
module heat_col_m10k #(
  parameter int DEPTH = 480,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic [DW-1:0] o_a_rdata,
  input  logic [AW-1:0] i_b_addr,
  output logic [DW-1:0] o_b_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_a_q;
  logic [AW-1:0] r_b_addr;
  logic [DW-1:0] r_b_q;

  always_ff @(posedge i_clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    r_a_q <= r_mem[i_a_addr];
  end

  // Non-blocking read of the array gives old data on a same-address collision.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_b_addr <= '0;
      r_b_q    <= '0;
    end else begin
      r_b_addr <= i_b_addr;
      r_b_q    <= r_mem[r_b_addr];
    end
  end

  assign o_a_rdata = r_a_q;
  assign o_b_rdata = r_b_q;

endmodule

// File: rtl/heat_column_store.sv
// Per-column heat pixel store: four-phase write/accumulate port, clear sweep, VGA read port.
module heat_column_store #(
  parameter int ROWS  = heat_pkg::ROWS,
  parameter int ROW_W = heat_pkg::ROW_W,
  parameter int VAL_W = heat_pkg::VAL_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             col_sel,
  input  logic [ROW_W-1:0] row_sel,
  input  logic [VAL_W-1:0] wr_data,
  input  logic             accum_en,
  output logic             col_ack,
  input  logic             clear_req,
  input  logic [VAL_W-1:0] clear_val,
  output logic             clear_busy,
  output logic             range_err,
  input  logic [ROW_W-1:0] vga_row,
  output logic [VAL_W-1:0] vga_data
);
  import heat_pkg::*;

  state_t           r_state, w_state_nx;
  logic [ROW_W-1:0] r_row, r_clr_addr, w_clr_addr_nx, w_addr_a;
  logic [VAL_W-1:0] r_data, r_clr_val, w_wdata, w_rdata_a;
  logic             r_acc, r_ack, r_busy, r_err, r_pend;
  logic             w_ack_nx, w_busy_nx, w_err_nx, w_pend_nx;
  logic             w_latch_req, w_latch_clr, w_we;

  always_comb begin
    w_state_nx    = r_state;
    w_ack_nx      = r_ack;
    w_busy_nx     = r_busy;
    w_err_nx      = r_err;
    w_pend_nx     = r_pend;
    w_clr_addr_nx = r_clr_addr;
    w_latch_req   = 1'b0;
    w_latch_clr   = 1'b0;
    w_we          = 1'b0;
    w_addr_a      = r_row;
    w_wdata       = r_data;
    if (clear_req && r_state != IDLE && r_state != CLEAR) w_pend_nx = 1'b1;
    case (r_state)
      IDLE: begin
        if (clear_req || r_pend) begin
          w_state_nx    = CLEAR;
          w_clr_addr_nx = '0;
          w_latch_clr   = 1'b1;
          w_busy_nx     = 1'b1;
          w_pend_nx     = 1'b0;
        end else if (col_sel) begin
          w_latch_req = 1'b1;
          if (row_sel >= ROW_W'(ROWS)) begin
            w_err_nx   = 1'b1;
            w_ack_nx   = 1'b1;
            w_state_nx = ACK;
          end else if (accum_en) begin
            w_state_nx = RD_ADDR;
          end else begin
            w_state_nx = WRITE;
          end
        end
      end
      CLEAR: begin
        w_we     = 1'b1;
        w_addr_a = r_clr_addr;
        w_wdata  = r_clr_val;
        if (r_clr_addr == ROW_W'(ROWS - 1)) begin
          w_busy_nx  = 1'b0;
          w_err_nx   = 1'b0;
          w_state_nx = IDLE;
        end else begin
          w_clr_addr_nx = r_clr_addr + ROW_W'(1);
        end
      end
      RD_ADDR: w_state_nx = RD_WAIT;
      RD_WAIT: w_state_nx = WRITE;
      WRITE: begin
        w_we       = 1'b1;
        w_wdata    = r_acc ? sat_add(w_rdata_a, r_data) : r_data;
        w_ack_nx   = 1'b1;
        w_state_nx = ACK;
      end
      ACK: begin
        if (!col_sel) begin
          w_ack_nx   = 1'b0;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_pend     <= 1'b0;
      r_clr_addr <= '0;
      r_clr_val  <= '0;
      r_row      <= '0;
      r_data     <= '0;
      r_acc      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_ack      <= w_ack_nx;
      r_busy     <= w_busy_nx;
      r_err      <= w_err_nx;
      r_pend     <= w_pend_nx;
      r_clr_addr <= w_clr_addr_nx;
      if (w_latch_clr) r_clr_val <= clear_val;
      if (w_latch_req) begin
        r_row  <= row_sel;
        r_data <= wr_data;
        r_acc  <= accum_en;
      end
    end
  end

  heat_col_m10k #(
    .DEPTH(ROWS),
    .AW   (ROW_W),
    .DW   (VAL_W)
  ) u_mem (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_a_we   (w_we),
    .i_a_addr (w_addr_a),
    .i_a_wdata(w_wdata),
    .o_a_rdata(w_rdata_a),
    .i_b_addr (vga_row),
    .o_b_rdata(vga_data)
  );

  assign col_ack    = r_ack;
  assign clear_busy = r_busy;
  assign range_err  = r_err;

endmodule

// File: tb/tb_heat_column_store.sv
// Directed bench for heat_column_store with a latency/data scoreboard.
module tb_heat_column_store;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       col_sel = 1'b0;
  logic [9:0] row_sel = '0;
  logic [7:0] wr_data = '0;
  logic       accum_en = 1'b0;
  logic       col_ack;
  logic       clear_req = 1'b0;
  logic [7:0] clear_val = '0;
  logic       clear_busy;
  logic       range_err;
  logic [9:0] vga_row = '0;
  logic [7:0] vga_data;

  int         n_cmp = 0;
  int         n_err = 0;
  int         lat_q[$];
  logic [7:0] dat_q[$];

  always #5 clock = ~clock;

  heat_column_store dut (
    .clock     (clock),
    .reset     (reset),
    .col_sel   (col_sel),
    .row_sel   (row_sel),
    .wr_data   (wr_data),
    .accum_en  (accum_en),
    .col_ack   (col_ack),
    .clear_req (clear_req),
    .clear_val (clear_val),
    .clear_busy(clear_busy),
    .range_err (range_err),
    .vga_row   (vga_row),
    .vga_data  (vga_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Four-phase request; optionally pulses clear_req during cycle clr_at.
  task automatic do_req(input string tag, input logic [9:0] row, input logic [7:0] val,
                        input logic acc, input int lat, input int clr_at);
    int n;
    bit seen;
    lat_q.push_back(lat);
    col_sel = 1'b1; row_sel = row; wr_data = val; accum_en = acc;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      if (col_ack) seen = 1;
      else begin
        step();
        n++;
        clear_req = (n == clr_at);
      end
    end
    clear_req = 1'b0;
    check({tag, "_ack_lat"}, seen ? n : -1, lat_q.pop_front());
    col_sel = 1'b0;
    step();
    check({tag, "_ack_drop"}, col_ack, 0);
  endtask

  task automatic vga_chk(input string tag, input logic [9:0] row, input logic [7:0] exp);
    dat_q.push_back(exp);
    vga_row = row;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check(tag, vga_data, dat_q.pop_front());
  endtask

  task automatic run_clear(input string tag, input logic [7:0] val);
    int n;
    clear_val = val; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    n = 0;
    while (clear_busy && n < 1000) begin n++; step(); end
    check({tag, "_busy_cycles"}, n, 480);
  endtask

  initial begin
    int n;
    @(negedge clock);
    check("rst_ack", col_ack, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_err", range_err, 0);
    check("rst_vga", vga_data, 0);
    reset = 1'b0;
    step();

    run_clear("clr1", 8'hF6);
    check("clr1_err", range_err, 0);
    vga_chk("clr1_r0", 10'd0, 8'hF6);
    vga_chk("clr1_r239", 10'd239, 8'hF6);
    vga_chk("clr1_r479", 10'd479, 8'hF6);

    do_req("ow5", 10'd5, 8'h23, 1'b0, 2, -1);
    vga_chk("ow5_vga", 10'd5, 8'h23);

    do_req("ow7", 10'd7, 8'd100, 1'b0, 2, -1);
    do_req("ow8", 10'd8, 8'h9C, 1'b0, 2, -1);
    do_req("acc7", 10'd7, 8'd50, 1'b1, 4, -1);
    do_req("acc8", 10'd8, 8'hC4, 1'b1, 4, -1);
    do_req("acc5", 10'd5, 8'h10, 1'b1, 4, -1);
    vga_chk("acc7_vga", 10'd7, 8'h7F);
    vga_chk("acc8_vga", 10'd8, 8'h80);
    vga_chk("acc5_vga", 10'd5, 8'h33);

    do_req("ow479", 10'd479, 8'h11, 1'b0, 2, -1);
    check("ow479_err", range_err, 0);
    vga_chk("ow479_vga", 10'd479, 8'h11);
    do_req("oor480", 10'd480, 8'h55, 1'b0, 1, -1);
    check("oor480_err", range_err, 1);
    vga_chk("oor_r479", 10'd479, 8'h11);

    // Clear and request together: clear first, then row 3 gets 9.
    lat_q.push_back(2);
    clear_val = 8'h05; clear_req = 1'b1;
    col_sel = 1'b1; row_sel = 10'd3; wr_data = 8'd9; accum_en = 1'b0;
    step();
    clear_req = 1'b0;
    check("cvr_busy_start", clear_busy, 1);
    n = 0;
    while (clear_busy && n < 1000) begin n++; step(); end
    check("cvr_busy_cycles", n, 480);
    check("cvr_err", range_err, 0);
    n = 0;
    while (!col_ack && n < 20) begin n++; step(); end
    check("cvr_ack_after_clr", n, lat_q.pop_front());
    col_sel = 1'b0;
    step();
    check("cvr_ack_drop", col_ack, 0);
    vga_chk("cvr_r3", 10'd3, 8'd9);
    vga_chk("cvr_r479", 10'd479, 8'h05);

    // Clear requested mid-accumulate runs after the handshake finishes.
    clear_val = 8'h44;
    do_req("pend", 10'd3, 8'd1, 1'b1, 4, 1);
    check("pend_idle", clear_busy, 0);
    step();
    check("pend_busy_start", clear_busy, 1);
    n = 0;
    while (clear_busy && n < 1000) begin n++; step(); end
    check("pend_busy_cycles", n, 480);
    vga_chk("pend_r3", 10'd3, 8'h44);

    do_req("oor500", 10'd500, 8'h01, 1'b0, 1, -1);
    check("oor500_err", range_err, 1);

    col_sel = 1'b1; row_sel = 10'd7; wr_data = 8'd3; accum_en = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    check("arst_ack", col_ack, 0);
    check("arst_busy", clear_busy, 0);
    check("arst_err", range_err, 0);
    check("arst_vga", vga_data, 0);
    @(negedge clock);
    reset = 1'b0; col_sel = 1'b0; accum_en = 1'b0;
    step();
    do_req("post_rst", 10'd6, 8'h42, 1'b0, 2, -1);
    vga_chk("post_rst_r6", 10'd6, 8'h42);
    vga_chk("post_rst_r7", 10'd7, 8'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
